// File: rtl/prog_clk_div.sv
// prog_clk_div: synchronous programmable clock divider.
//
// Divides CLK by a programmable ratio N (DIV, with 0 and 1 treated as 2).
// Produces a registered near-50%-duty divided clock CLK_OUT (high for
// ceil(N/2) cycles, low for the remainder) and a registered one-cycle TICK
// in the last CLK cycle of each output period. Downstream logic should use
// TICK as a clock enable on CLK rather than clocking on CLK_OUT.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST      in   asynchronous active-high reset
//   EN       in   run enable; low freezes the divider
//   LOAD     in   synchronous restart with immediate adoption of DIV
//   DIV      in   [WIDTH] requested divide ratio
//   CLK_OUT  out  divided clock (registered)
//   TICK     out  end-of-period strobe (registered)
//   CNT      out  [WIDTH] current phase count, 0..ratio-1
//
// state | meaning
// IDLE  | not started; ratio tracks DIV, outputs low
// RUN   | counting phases, ratio changes adopted only at the wrap
// HOLD  | EN low after running; count, ratio and CLK_OUT frozen, TICK low

module prog_clk_div #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIV,
    output logic             CLK_OUT,
    output logic             TICK,
    output logic [WIDTH-1:0] CNT
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] div_r, div_nxt;
    logic [WIDTH-1:0] div_eff;
    logic             wrap;
    logic [WIDTH:0]   high_cnt;
    logic             clk_out_nxt;
    logic             tick_nxt;

    assign div_eff = (DIV < TWO) ? TWO : DIV;
    assign wrap    = (cnt == div_r - ONE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            div_r   <= TWO;
            CLK_OUT <= 1'b0;
            TICK    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            div_r   <= div_nxt;
            CLK_OUT <= clk_out_nxt;
            TICK    <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        div_nxt   = div_r;

        case (state)
            IDLE: begin
                div_nxt = div_eff;
                cnt_nxt = '0;
                if (EN) begin
                    state_nxt = RUN;
                end
            end
            RUN, HOLD: begin
                if (!EN) begin
                    state_nxt = HOLD;
                end else begin
                    // Returning from HOLD takes the next step immediately,
                    // so counting resumes at frozen cnt + 1.
                    state_nxt = RUN;
                    if (wrap) begin
                        cnt_nxt = '0;
                        div_nxt = div_eff;
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                div_nxt   = TWO;
            end
        endcase

        if (LOAD) begin
            cnt_nxt   = '0;
            div_nxt   = div_eff;
            state_nxt = EN ? RUN : IDLE;
        end
    end

    // Outputs are registered from the post-edge count and ratio. The extra
    // bit keeps (ratio+1)/2 exact at the maximum ratio.
    assign high_cnt    = ({1'b0, div_nxt} + (WIDTH+1)'(1)) >> 1;
    assign clk_out_nxt = (state_nxt != IDLE) && ({1'b0, cnt_nxt} < high_cnt);
    assign tick_nxt    = (state_nxt == RUN) && (cnt_nxt == div_nxt - ONE);

    assign CNT = cnt;

endmodule

// File: tb/tb_prog_clk_div.sv
module tb_prog_clk_div;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic       LOAD = 1'b0;
    logic [7:0] DIV = 8'd4;
    logic       CLK_OUT;
    logic       TICK;
    logic [7:0] CNT;

    int errors = 0;
    int checks = 0;

    // Reference model: divider described as "started / paused / phase / ratio".
    bit m_active;
    bit m_paused;
    int m_phase;
    int m_ratio;

    prog_clk_div #(.WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .DIV(DIV),
        .CLK_OUT(CLK_OUT), .TICK(TICK), .CNT(CNT)
    );

    always #5 CLK = ~CLK;

    function automatic int eff(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_paused = 0;
        m_phase  = 0;
        m_ratio  = 2;
    endtask

    task automatic model_step();
        if (LOAD) begin
            m_ratio  = eff(int'(DIV));
            m_phase  = 0;
            m_active = EN;
            m_paused = 0;
        end else if (!m_active) begin
            m_ratio = eff(int'(DIV));
            m_phase = 0;
            if (EN) m_active = 1;
        end else if (!EN) begin
            m_paused = 1;
        end else begin
            m_paused = 0;
            if (m_phase == m_ratio - 1) begin
                m_phase = 0;
                m_ratio = eff(int'(DIV));
            end else begin
                m_phase = m_phase + 1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic       e_clk;
        logic       e_tick;
        logic [7:0] e_cnt;
        e_clk  = m_active && (m_phase < (m_ratio + 1) / 2);
        e_tick = m_active && !m_paused && (m_phase == m_ratio - 1);
        e_cnt  = 8'(m_phase);
        checks++;
        assert (CLK_OUT === e_clk) else begin
            errors++;
            $error("FAIL %s clk_out observed=%0b expected=%0b", tag, CLK_OUT, e_clk);
        end
        checks++;
        assert (TICK === e_tick) else begin
            errors++;
            $error("FAIL %s tick observed=%0b expected=%0b", tag, TICK, e_tick);
        end
        checks++;
        assert (CNT === e_cnt) else begin
            errors++;
            $error("FAIL %s cnt observed=%0d expected=%0d", tag, CNT, e_cnt);
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge CLK);
        if (RST) model_reset();
        else model_step();
        #1;
        check_outputs(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    task automatic wait_cnt(input int target, input string tag);
        int n;
        n = 0;
        while (int'(CNT) != target && n < 600) begin
            cyc(tag);
            n++;
        end
        checks++;
        assert (int'(CNT) == target) else begin
            errors++;
            $error("FAIL %s_timeout cnt observed=%0d expected=%0d", tag, CNT, target);
        end
    endtask

    task automatic load_div(input int d, input string tag);
        DIV  = 8'(d);
        LOAD = 1'b1;
        cyc(tag);
        LOAD = 1'b0;
    endtask

    // Called shortly after a check: reset mid-cycle, check before any edge.
    task automatic async_reset(input string tag);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        cyc(tag);
        RST = 1'b0;
    endtask

    initial begin
        int hi;
        int ticks;
        model_reset();

        // Reset state, before any edge and across an edge.
        #1;
        check_outputs("reset_pre_edge");
        cyc("reset_edge");
        RST = 1'b0;

        // DIV=4
        DIV = 8'd4;
        EN  = 1'b1;
        run(12, "div4");

        // DIV=5, then ratio-2 cases from 0 and 1
        load_div(5, "div5_load");
        run(10, "div5");
        load_div(0, "div0_load");
        run(4, "div0");
        load_div(1, "div1_load");
        run(4, "div1");

        // DIV change mid-period: adopted at wrap
        load_div(4, "chg_load");
        wait_cnt(1, "chg_wait");
        DIV = 8'd6;
        run(14, "chg_wrap");

        // Same change with a LOAD pulse: immediate restart
        load_div(4, "chgl_load4");
        wait_cnt(1, "chgl_wait");
        load_div(6, "chgl_load6");
        run(8, "chgl_run");

        // EN dropped at CNT=5 for 3 cycles with DIV=8
        load_div(8, "hold_load");
        wait_cnt(5, "hold_wait");
        EN = 1'b0;
        DIV = 8'd3;
        run(3, "hold_frozen");
        EN = 1'b1;
        run(12, "hold_resume");

        // LOAD with EN low goes to idle
        EN = 1'b0;
        load_div(7, "load_idle");
        run(2, "idle");
        EN = 1'b1;
        run(9, "idle_start");

        // Async reset mid-period at CNT=2, DIV=6
        load_div(6, "rst_load");
        wait_cnt(2, "rst_wait");
        async_reset("rst_async");
        run(4, "rst_restart");

        // Maximum ratio
        load_div(255, "max_load");
        hi    = int'(CLK_OUT);
        ticks = int'(TICK);
        for (int i = 1; i < 255; i++) begin
            cyc("max_run");
            hi    += int'(CLK_OUT);
            ticks += int'(TICK);
        end
        checks++;
        assert (hi == 128) else begin
            errors++;
            $error("FAIL max_high_cycles observed=%0d expected=%0d", hi, 128);
        end
        checks++;
        assert (ticks == 1) else begin
            errors++;
            $error("FAIL max_ticks observed=%0d expected=%0d", ticks, 1);
        end
        run(3, "max_wrap");

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rnd_rst");
            end
            EN   = ($urandom_range(0, 7) != 0);
            LOAD = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 15) == 0) begin
                DIV = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(0, 12));
            end
            cyc("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_clk_div.md
Name: prog_clk_div

Overview:
Synchronous programmable clock divider. Replaces the fixed ripple /2 /4 /8 chain as the source of divided timing for downstream logic. From the single system clock it produces a near-50%-duty divided output CLK_OUT and a one-cycle TICK strobe per output period. All state is on one clock domain, so consumers can use TICK as a clock enable instead of clocking on ripple outputs.

Parameters:
WIDTH, 8, width of the divide-ratio input and internal counter

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  asynchronous active-high reset
EN  input  1  run enable; low freezes the divider
LOAD  input  1  synchronous restart; forces immediate adoption of DIV and count restart
DIV  input  WIDTH  requested divide ratio N; values 0 and 1 are treated as 2
CLK_OUT  output  1  divided clock, registered
TICK  output  1  one-cycle strobe in the last CLK cycle of each CLK_OUT period, registered
CNT  output  WIDTH  current phase count, 0..div_r-1

Behaviour:
- Interface: one clock (CLK); reset RST is asynchronous and active-high.
- eff(DIV) = 2 if DIV < 2, else DIV. H(n) = (n+1)>>1 = number of high cycles per period (ceil(n/2)).
- Internal state: state in {IDLE, RUN, HOLD}; cnt (WIDTH bits); div_r (WIDTH bits, active ratio).
- Reset (async, immediate): state=IDLE, cnt=0, div_r=2, CLK_OUT=0, TICK=0. Outputs hold these values while RST=1.
- Registered output rule: after every edge in RUN or HOLD, CLK_OUT = (cnt < H(div_r)). In RUN, TICK = (cnt == div_r-1). TICK=0 in IDLE and HOLD. CLK_OUT=0 in IDLE. Outputs come from flops; they are never combinational decodes.
- IDLE:
  - EN=0: stay, and load div_r <= eff(DIV) each cycle.
  - EN=1: go to RUN with cnt=0 and div_r=eff(DIV). CLK_OUT=1 after this edge.
- RUN:
  - EN=1, LOAD=0: if cnt == div_r-1, cnt <= 0 and div_r <= eff(DIV), so a DIV change takes effect only at the period boundary. Otherwise cnt <= cnt+1.
  - EN=0: go to HOLD. cnt, div_r and CLK_OUT are frozen; TICK is forced to 0.
- HOLD:
  - EN=1: return to RUN and resume counting from the frozen cnt.
  - A DIV change while in HOLD is not adopted until the next wrap.
- LOAD=1 (any state, priority over EN-driven transitions):
  - cnt <= 0, div_r <= eff(DIV).
  - state <= RUN if EN=1, else IDLE.
  - If RUN results, CLK_OUT=1 after the edge; if IDLE results, CLK_OUT=0.
- Period and duty: output period = div_r cycles; high H(div_r) cycles, low div_r-H(div_r) cycles. An odd ratio gives one extra high cycle. div_r=2 reproduces CLK/2.
- Counter: never exceeds div_r-1. The maximum ratio 2^WIDTH-1 must wrap correctly, with no overflow in the H computation; use WIDTH+1 bits internally.
- Mid-operation RST: asynchronously returns to reset values. The first valid period starts at the first EN=1 edge after release.

Test Plan:
- Reset, DIV=4, EN=1: CLK_OUT 1,1,0,0 repeating; TICK high on every 4th cycle (CNT=3); CNT 0,1,2,3.
- DIV=5: CLK_OUT 1,1,1,0,0; TICK when CNT=4. DIV=0 and DIV=1 each give a toggle every cycle (ratio 2) with TICK on alternate cycles.
- DIV=4 running, change DIV to 6 at CNT=1: the current period completes as 4 cycles; the next period is 6 cycles (1,1,1,0,0,0). Same change with a LOAD pulse: cnt restarts at 0 immediately with ratio 6.
- DIV=8, EN dropped at CNT=5 for 3 cycles: CNT stays 5, CLK_OUT stays 0, TICK stays 0. On EN rise, counting resumes 6,7, then TICK at CNT=7.
- RST asserted mid-period at CNT=2 with DIV=6: outputs go to 0 immediately, before any clock edge. After release with EN=1, CLK_OUT=1 and CNT=0 after the first edge.
- DIV=255 (WIDTH=8): period 255 cycles, 128 high and 127 low, one TICK per period, no counter overflow.
